int_ctxt_ctrl: RTL

INT_CTXT_CTRL -- requirements
Module: int_ctxt_ctrl
Interface
REQ-001 DATA_WIDTH, 16, width of bit_cnt and mask fields.
REQ-002 DATA_DEPTH, 128, width of C_F field.
REQ-003 ADDR_WIDTH_MEM, 16, width of pc and ctxt_addr fields.
REQ-004 STACK_DEPTH, 8, maximum stacked contexts; must equal the context stack's depth.
REQ-005 ISR_ADDR, 16'h0100, ISR entry address loaded on interrupt entry.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  reset; asynchronous, active-low.
REQ-008 irq  in  1  level interrupt request.
REQ-009 instr_bnd  in  1  one-cycle pulse marking an instruction boundary.
REQ-010 reti  in  1  return-from-interrupt decoded; valid only with instr_bnd.
REQ-011 cur_ctxt  in  CTXT_W  live context {pc,ctxt_addr,bit_cnt,pass,mask,C_F}, MSB first.
REQ-012 int_set  out  1  save request to the context stack.
REQ-013 ret_valid  out  1  restore request to the context stack.
REQ-014 ret_addr  out  ADDR_WIDTH_MEM  saved pc.
REQ-015 ctxt_addr  out  ADDR_WIDTH_MEM  saved context address.
REQ-016 tmp_bit_cnt  out  DATA_WIDTH  saved bit counter.
REQ-017 tmp_pass  out  3  saved pass index.
REQ-018 tmp_mask  out  DATA_WIDTH  saved mask.
REQ-019 tmp_C_F  out  DATA_DEPTH  saved carry/flag column.
REQ-020 ctxt_rdy  in  1  stack has restored data valid on *_ret.
REQ-021 ret_addr_ret  in  ADDR_WIDTH_MEM  restored pc.
REQ-022 ctxt_addr_ret  in  ADDR_WIDTH_MEM  restored context address.
REQ-023 tmp_bit_cnt_ret  in  DATA_WIDTH  restored bit counter.
REQ-024 tmp_pass_ret  in  3  restored pass index.
REQ-025 tmp_mask_ret  in  DATA_WIDTH  restored mask.
REQ-026 tmp_C_F_ret  in  DATA_DEPTH  restored carry/flag column.
REQ-027 stall  out  1  freezes controller; high whenever state != IDLE.
REQ-028 pc_load  out  1  one-cycle pc load strobe.
REQ-029 pc_load_val  out  ADDR_WIDTH_MEM  pc value for pc_load.
REQ-030 ctxt_load  out  1  one-cycle strobe; res_ctxt to be written to live registers.
REQ-031 res_ctxt  out  CTXT_W-ADDR_WIDTH_MEM  restored {ctxt_addr,bit_cnt,pass,mask,C_F}.
REQ-032 err  out  1  one-cycle pulse on reti with depth 0.
Function
REQ-033 FSM states IDLE, SAVE, ENTER, RET_REQ, WAIT_RDY, RESUME; depth counter 0..STACK_DEPTH; all outputs registered.
REQ-034 IDLE, instr_bnd=1: reti=1 with depth>0 -> RET_REQ; reti=1 with depth=0 -> err pulse, stay IDLE; else irq=1 with depth<STACK_DEPTH -> SAVE, capturing cur_ctxt into save registers; reti wins over simultaneous irq; irq at depth=STACK_DEPTH ignored, stays pending.
REQ-035 SAVE: int_set=1 exactly one cycle, depth+1, -> ENTER; ret_addr..tmp_C_F stable from SAVE through ENTER.
REQ-036 ENTER: int_set=0, pc_load=1, pc_load_val=ISR_ADDR, -> IDLE; entry latency boundary-to-pc_load 2 cycles; int_set low >=1 cycle between requests.
REQ-037 RET_REQ: ret_valid=1 exactly one cycle -> WAIT_RDY; WAIT_RDY: ret_valid=0, wait unbounded for ctxt_rdy=1.
REQ-038 WAIT_RDY with ctxt_rdy=1: capture all *_ret inputs, depth-1, -> RESUME; ctxt_rdy outside WAIT_RDY ignored.
REQ-039 RESUME: pc_load=1, pc_load_val=captured ret_addr_ret, ctxt_load=1, res_ctxt=captured fields, -> IDLE; instr_bnd/irq/reti ignored in all non-IDLE states.
Reset
REQ-040 rst low (also mid-operation): state IDLE, depth 0, every output and capture register 0, no int_set/ret_valid pulse emitted on release.
Configuration
REQ-041 INT_NEST_EN defined: irq accepted at any depth<STACK_DEPTH (nested interrupts).
REQ-042 INT_NEST_EN undefined: irq accepted only at depth=0; depth never exceeds 1.
Structure
REQ-043 Package int_ctxt_pkg holds state encoding, CTXT_W = 2*ADDR_WIDTH_MEM+2*DATA_WIDTH+3+DATA_DEPTH and field offsets; no sub-module.
Verification
REQ-044 irq=1, instr_bnd pulse, cur pc=16'h0042 -> int_set 1 cycle later with ret_addr=16'h0042, pc_load with 16'h0100 the cycle after.
REQ-045 enter then reti at boundary, stack model ctxt_rdy after 3 cycles with ret_addr_ret=16'h0042 -> pc_load 16'h0042 and ctxt_load together, depth 0.
REQ-046 reti at depth 0 -> err 1 cycle, no ret_valid; irq+reti same boundary at depth 1 -> return taken.
REQ-047 INT_NEST_EN: 9 irqs -> 8 int_set pulses, 9th ignored; without macro 2nd irq ignored; rst low in WAIT_RDY -> all outputs 0.

---
 rtl/int_ctxt_pkg.sv | 33 +++
 rtl/int_ctxt_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/int_ctxt_pkg.sv
// Shared sizing, context field layout and FSM encoding for the interrupt context controller.
// The context is packed MSB first as {pc, ctxt_addr, bit_cnt, pass, mask, C_F}.
package int_ctxt_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int DATA_DEPTH     = 128;
  localparam int ADDR_WIDTH_MEM = 16;
  localparam int STACK_DEPTH    = 8;
  localparam int PASS_W         = 3;

  localparam logic [ADDR_WIDTH_MEM-1:0] ISR_ADDR = 16'h0100;

  localparam int CTXT_W  = 2*ADDR_WIDTH_MEM + 2*DATA_WIDTH + PASS_W + DATA_DEPTH;
  localparam int RES_W   = CTXT_W - ADDR_WIDTH_MEM;
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  localparam int CF_LSB    = 0;
  localparam int MASK_LSB  = CF_LSB + DATA_DEPTH;
  localparam int PASS_LSB  = MASK_LSB + DATA_WIDTH;
  localparam int BCNT_LSB  = PASS_LSB + PASS_W;
  localparam int CADDR_LSB = BCNT_LSB + DATA_WIDTH;
  localparam int PC_LSB    = CADDR_LSB + ADDR_WIDTH_MEM;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAVE     = 3'd1,
    ST_ENTER    = 3'd2,
    ST_RET_REQ  = 3'd3,
    ST_WAIT_RDY = 3'd4,
    ST_RESUME   = 3'd5
  } state_e;

endpackage

// File: rtl/int_ctxt_ctrl.sv
// Interrupt entry/return sequencer: saves the live context to a stack and reloads it on reti.
// Entry: boundary to pc_load in 2 cycles; return waits unbounded on ctxt_rdy. INT_NEST_EN enables nesting.
module int_ctxt_ctrl
  import int_ctxt_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      irq,
  input  logic                      instr_bnd,
  input  logic                      reti,
  input  logic [CTXT_W-1:0]         cur_ctxt,
  output logic                      int_set,
  output logic                      ret_valid,
  output logic [ADDR_WIDTH_MEM-1:0] ret_addr,
  output logic [ADDR_WIDTH_MEM-1:0] ctxt_addr,
  output logic [DATA_WIDTH-1:0]     tmp_bit_cnt,
  output logic [PASS_W-1:0]         tmp_pass,
  output logic [DATA_WIDTH-1:0]     tmp_mask,
  output logic [DATA_DEPTH-1:0]     tmp_C_F,
  input  logic                      ctxt_rdy,
  input  logic [ADDR_WIDTH_MEM-1:0] ret_addr_ret,
  input  logic [ADDR_WIDTH_MEM-1:0] ctxt_addr_ret,
  input  logic [DATA_WIDTH-1:0]     tmp_bit_cnt_ret,
  input  logic [PASS_W-1:0]         tmp_pass_ret,
  input  logic [DATA_WIDTH-1:0]     tmp_mask_ret,
  input  logic [DATA_DEPTH-1:0]     tmp_C_F_ret,
  output logic                      stall,
  output logic                      pc_load,
  output logic [ADDR_WIDTH_MEM-1:0] pc_load_val,
  output logic                      ctxt_load,
  output logic [RES_W-1:0]          res_ctxt,
  output logic                      err
);

  state_e                      state_q, state_d;
  logic [DEPTH_W-1:0]          depth_q, depth_d;
  logic [CTXT_W-1:0]           save_q, save_d;
  logic [RES_W-1:0]            res_q, res_d;
  logic [ADDR_WIDTH_MEM-1:0]   pcv_q, pcv_d;
  logic                        int_set_q, int_set_d;
  logic                        ret_valid_q, ret_valid_d;
  logic                        pc_load_q, pc_load_d;
  logic                        ctxt_load_q, ctxt_load_d;
  logic                        stall_q, stall_d;
  logic                        err_q, err_d;
  logic                        irq_ok;

`ifdef INT_NEST_EN
  assign irq_ok = (depth_q < DEPTH_W'(STACK_DEPTH));
`else
  assign irq_ok = (depth_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    save_d  = save_q;
    res_d   = res_q;
    pcv_d   = pcv_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // reti takes priority; a refused irq simply stays pending on the level input
        if (instr_bnd) begin
          if (reti) begin
            if (depth_q != '0) state_d = ST_RET_REQ;
            else               err_d   = 1'b1;
          end else if (irq && irq_ok) begin
            state_d = ST_SAVE;
            save_d  = cur_ctxt;
          end
        end
      end
      ST_SAVE: begin
        depth_d = depth_q + DEPTH_W'(1);
        pcv_d   = ISR_ADDR;
        state_d = ST_ENTER;
      end
      ST_ENTER:   state_d = ST_IDLE;
      ST_RET_REQ: state_d = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (ctxt_rdy) begin
          pcv_d   = ret_addr_ret;
          res_d   = {ctxt_addr_ret, tmp_bit_cnt_ret, tmp_pass_ret, tmp_mask_ret, tmp_C_F_ret};
          depth_d = depth_q - DEPTH_W'(1);
          state_d = ST_RESUME;
        end
      end
      ST_RESUME:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so every output comes straight from a flop.
    int_set_d   = (state_d == ST_SAVE);
    ret_valid_d = (state_d == ST_RET_REQ);
    pc_load_d   = (state_d == ST_ENTER) || (state_d == ST_RESUME);
    ctxt_load_d = (state_d == ST_RESUME);
    stall_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      depth_q     <= '0;
      save_q      <= '0;
      res_q       <= '0;
      pcv_q       <= '0;
      int_set_q   <= 1'b0;
      ret_valid_q <= 1'b0;
      pc_load_q   <= 1'b0;
      ctxt_load_q <= 1'b0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      save_q      <= save_d;
      res_q       <= res_d;
      pcv_q       <= pcv_d;
      int_set_q   <= int_set_d;
      ret_valid_q <= ret_valid_d;
      pc_load_q   <= pc_load_d;
      ctxt_load_q <= ctxt_load_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end

  assign int_set     = int_set_q;
  assign ret_valid   = ret_valid_q;
  assign pc_load     = pc_load_q;
  assign pc_load_val = pcv_q;
  assign ctxt_load   = ctxt_load_q;
  assign res_ctxt    = res_q;
  assign stall       = stall_q;
  assign err         = err_q;

  assign ret_addr    = save_q[PC_LSB    +: ADDR_WIDTH_MEM];
  assign ctxt_addr   = save_q[CADDR_LSB +: ADDR_WIDTH_MEM];
  assign tmp_bit_cnt = save_q[BCNT_LSB  +: DATA_WIDTH];
  assign tmp_pass    = save_q[PASS_LSB  +: PASS_W];
  assign tmp_mask    = save_q[MASK_LSB  +: DATA_WIDTH];
  assign tmp_C_F     = save_q[CF_LSB    +: DATA_DEPTH];

endmodule
